block_relay_buffer: RTL

BLOCK_RELAY_BUFFER -- requirements
Module: block_relay_buffer

---
 rtl/block_relay_buffer_pkg.sv | 14 +
 rtl/block_word_swapper.sv | 25 ++
 rtl/block_relay_buffer.sv | 112 +++++++++++
 3 files changed

// File: rtl/block_relay_buffer_pkg.sv
// Shared constants and occupancy-state encoding for the block relay buffer.
package block_relay_buffer_pkg;

    localparam int WSIZE_DEF       = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int BSIZE_DEF       = WSIZE_DEF * WORDS_PER_BLOCK;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

endpackage

// File: rtl/block_word_swapper.sv
// Combinational reversal of the four words in a block, selected by swap.
module block_word_swapper
    import block_relay_buffer_pkg::*;
#(
    parameter int WSIZE = WSIZE_DEF,
    parameter int BSIZE = WSIZE * WORDS_PER_BLOCK
) (
    input  logic [BSIZE-1:0] block_in,
    input  logic             swap,
    output logic [BSIZE-1:0] block_out
);

    logic [BSIZE-1:0] reversed;

    genvar w;
    generate
        for (w = 0; w < WORDS_PER_BLOCK; w++) begin : g_word
            assign reversed[w*WSIZE +: WSIZE] =
                block_in[(WORDS_PER_BLOCK-1-w)*WSIZE +: WSIZE];
        end
    endgenerate

    assign block_out = swap ? reversed : block_in;

endmodule

// File: rtl/block_relay_buffer.sv
// Small block FIFO between an upstream block producer and a downstream consumer,
// with optional word reversal on write, pop counter and sticky overrun flag.
module block_relay_buffer
    import block_relay_buffer_pkg::*;
#(
    parameter int WSIZE = WSIZE_DEF,
    parameter int BSIZE = WSIZE * WORDS_PER_BLOCK,
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [BSIZE-1:0]         block_in,
    input  logic                     block_in_ready,
    output logic                     block_in_hold,
    output logic [BSIZE-1:0]         block_out,
    output logic                     block_out_ready,
    input  logic                     pull_block,
    input  logic                     word_swap,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [15:0]              block_count,
    output logic                     overrun
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    logic [BSIZE-1:0] slots [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [BSIZE-1:0] swapped;
    logic [OW-1:0]    occ_next;
    logic             push;
    logic             pop;
    logic             hold_next;
    occ_state_t       state;
    occ_state_t       state_next;

    block_word_swapper #(
        .WSIZE (WSIZE),
        .BSIZE (BSIZE)
    ) u_swapper (
        .block_in  (block_in),
        .swap      (word_swap),
        .block_out (swapped)
    );

    assign block_out_ready = (occupancy != '0);
    assign block_out       = slots[rd_ptr];
    // Hold already reflects a full buffer, so a pop on the same edge cannot open a push slot.
    assign push            = block_in_ready && !block_in_hold;
    assign pop             = block_out_ready && pull_block;

    always_comb begin
        occ_next   = occupancy;
        state_next = state;
        hold_next  = 1'b0;
        case ({push, pop})
            2'b10:   occ_next = occupancy + OW'(1);
            2'b01:   occ_next = occupancy - OW'(1);
            default: occ_next = occupancy;
        endcase
        case (state)
            OCC_EMPTY: begin
                if (push && !pop)
                    state_next = OCC_PARTIAL;
            end
            OCC_PARTIAL: begin
                if (push && !pop && occupancy == OW'(DEPTH - 1))
                    state_next = OCC_FULL;
                else if (pop && !push && occupancy == OW'(1))
                    state_next = OCC_EMPTY;
            end
            OCC_FULL: begin
                if (pop && !push)
                    state_next = OCC_PARTIAL;
            end
            default: state_next = OCC_EMPTY;
        endcase
        hold_next = (state_next == OCC_FULL);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= OCC_EMPTY;
            occupancy     <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            block_count   <= '0;
            overrun       <= 1'b0;
            block_in_hold <= 1'b0;
        end else begin
            state         <= state_next;
            occupancy     <= occ_next;
            block_in_hold <= hold_next;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr      <= rd_ptr + PW'(1);
                block_count <= block_count + 16'd1;
            end
            if (block_in_ready && block_in_hold)
                overrun <= 1'b1;
        end
    end

    // Slot contents carry no reset; stale data is never visible while empty.
    always_ff @(posedge clock) begin
        if (!reset && push)
            slots[wr_ptr] <= swapped;
    end

endmodule
